// File: rtl/wb_master_port_ctrl_if.sv
// wb_bus_t: classic Wishbone bus toward one crossbar slave port, with crossbar grant
// master modport: drives cyc/stb/we/adr/sel/dat_ms/lock and tags, samples gnt/ack/err/rty/dat_sm
// slave modport: the mirror image, used by the crossbar side
interface wb_bus_t #(
  parameter int TAGSIZE = 2,
  parameter int WB_ADDR_W = 32
);
  logic                 wb_cyc;
  logic                 wb_stb;
  logic                 wb_we;
  logic                 wb_lock;
  logic [WB_ADDR_W-1:0] wb_adr;
  logic [3:0]           wb_sel;
  logic [31:0]          wb_dat_ms;
  logic [TAGSIZE-1:0]   wb_tga;
  logic [TAGSIZE-1:0]   wb_tgc;
  logic [TAGSIZE-1:0]   wb_tgd_ms;
  logic                 wb_gnt;
  logic                 wb_ack;
  logic                 wb_err;
  logic                 wb_rty;
  logic [31:0]          wb_dat_sm;
  modport master (
    output wb_cyc, wb_stb, wb_we, wb_lock, wb_adr, wb_sel, wb_dat_ms, wb_tga, wb_tgc, wb_tgd_ms,
    input  wb_gnt, wb_ack, wb_err, wb_rty, wb_dat_sm
  );
  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_lock, wb_adr, wb_sel, wb_dat_ms, wb_tga, wb_tgc, wb_tgd_ms,
    output wb_gnt, wb_ack, wb_err, wb_rty, wb_dat_sm
  );
endinterface

// File: rtl/wb_master_port_ctrl.sv
// wb_master_port_ctrl: core req/resp handshake to classic Wishbone initiator with grant, retry, timeout and lock
// clk_i/rst_i: clock and synchronous active-high reset
// req_i/ready_o + we_i/addr_i/wdata_i/be_i/lock_i: request side; unlock_i releases a held bus
// resp_valid_o/rdata_o/resp_status_o: one-cycle response (00 ok, 01 err, 10 retries exhausted, 11 timeout)
// wb_master_port: Wishbone master toward the crossbar
module wb_master_port_ctrl #(
  parameter int TAGSIZE = 2,
  parameter int WB_ADDR_W = 32,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_i,
  output logic                 ready_o,
  input  logic                 we_i,
  input  logic [WB_ADDR_W-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           be_i,
  input  logic                 lock_i,
  input  logic                 unlock_i,
  output logic                 resp_valid_o,
  output logic [31:0]          rdata_o,
  output logic [1:0]           resp_status_o,
  wb_bus_t.master              wb_master_port
);
  typedef enum logic [2:0] {IDLE, ARB, XFER, BACKOFF, HOLD} state_t;
  state_t               state_q, state_d;
  logic [3:0]           rty_q, rty_d;
  logic [7:0]           tmo_q, tmo_d;
  logic [4:0]           rty_inc;
  logic                 we_q, lock_q, lock_n, cap, term, rd_load, tmo_hit, gnt;
  logic [WB_ADDR_W-1:0] adr_q;
  logic [31:0]          dat_q;
  logic [3:0]           sel_q;
  logic [1:0]           status_d;
  assign gnt = wb_master_port.wb_gnt;
  assign tmo_hit = tmo_q == 8'(TIMEOUT - 1);
  assign rty_inc = {1'b0, rty_q} + 5'd1;
  // the response cycle already sits in IDLE, so acceptance waits one cycle unless the bus is held
  assign ready_o = (state_q == IDLE && !resp_valid_o) || state_q == HOLD;
  assign lock_n = cap ? lock_i : lock_q;
  assign wb_master_port.wb_we = we_q;
  assign wb_master_port.wb_adr = adr_q;
  assign wb_master_port.wb_sel = sel_q;
  assign wb_master_port.wb_dat_ms = dat_q;
  assign wb_master_port.wb_tga = {TAGSIZE{1'b0}};
  assign wb_master_port.wb_tgc = {TAGSIZE{1'b0}};
  assign wb_master_port.wb_tgd_ms = {TAGSIZE{1'b0}};
  always_comb begin
    state_d = state_q;
    cap = 1'b0;
    term = 1'b0;
    rd_load = 1'b0;
    status_d = 2'b00;
    rty_d = rty_q;
    tmo_d = tmo_q;
    case (state_q)
      IDLE: begin
        cap = req_i && ready_o;
        state_d = cap ? ARB : IDLE;
      end
      ARB: begin
        tmo_d = tmo_q + 8'd1;
        if (tmo_hit) begin
          term = 1'b1;
          status_d = 2'b11;
          state_d = IDLE;
        end else if (gnt) state_d = XFER;
      end
      XFER: begin
        tmo_d = tmo_q + 8'd1;
        // ack is broadcast by the crossbar, so only a granted termination belongs to us
        if (gnt && wb_master_port.wb_err) begin
          term = 1'b1;
          status_d = 2'b01;
          state_d = IDLE;
        end else if (gnt && wb_master_port.wb_rty) begin
          rty_d = rty_inc[3:0];
          term = rty_inc > 5'(MAX_RETRY);
          status_d = 2'b10;
          state_d = term ? IDLE : BACKOFF;
        end else if (gnt && wb_master_port.wb_ack) begin
          term = 1'b1;
          rd_load = !we_q;
          state_d = lock_q ? HOLD : IDLE;
        end else if (tmo_hit) begin
          term = 1'b1;
          status_d = 2'b11;
          state_d = IDLE;
        end
      end
      BACKOFF: begin
        tmo_d = '0;
        state_d = ARB;
      end
      HOLD: begin
        cap = gnt && req_i;
        state_d = !gnt ? IDLE : req_i ? XFER : unlock_i ? IDLE : HOLD;
      end
      default: state_d = IDLE;
    endcase
    if (cap) begin
      rty_d = '0;
      tmo_d = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rty_q <= '0;
      tmo_q <= '0;
      we_q <= 1'b0;
      lock_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      sel_q <= '0;
      wb_master_port.wb_cyc <= 1'b0;
      wb_master_port.wb_stb <= 1'b0;
      wb_master_port.wb_lock <= 1'b0;
      resp_valid_o <= 1'b0;
      rdata_o <= '0;
      resp_status_o <= '0;
    end else begin
      state_q <= state_d;
      rty_q <= rty_d;
      tmo_q <= tmo_d;
      if (cap) begin
        we_q <= we_i;
        lock_q <= lock_i;
        adr_q <= addr_i;
        dat_q <= wdata_i;
        sel_q <= be_i;
      end
      wb_master_port.wb_cyc <= state_d inside {ARB, XFER, HOLD};
      wb_master_port.wb_stb <= state_d == XFER;
      wb_master_port.wb_lock <= state_d == HOLD || (state_d inside {ARB, XFER} && lock_n);
      resp_valid_o <= term;
      if (term) resp_status_o <= status_d;
      if (rd_load) rdata_o <= wb_master_port.wb_dat_sm;
    end
  end
endmodule
